// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the program loader slice.
// The CHK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned BYTES_PER_WORD = INSTR_W / 8;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DONE  = 3'd2,
        ST_ERROR = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        ST_CHK   = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte of a word lands in the top byte.
// word_valid_c/word_c are combinational and describe the word completed this cycle.
module byte_packer
    import cpu_pkg::*;
#(
    parameter int unsigned B   = INSTR_W,
    parameter int unsigned BPW = BYTES_PER_WORD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic         word_valid_c,
    output logic [B-1:0] word_c
);

    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [B-1:0]     shreg_q;
    logic [CNT_W-1:0] cnt_q;

    assign word_valid_c = byte_valid && (cnt_q == LAST_CNT);
    assign word_c       = B'({shreg_q, byte_data});

    // Clear discards any partial word; it has priority over an incoming byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid) begin
            shreg_q <= word_c;
            cnt_q   <= word_valid_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into instruction memory as words until HALT, then raises cpu_enable.
// Optional trailing checksum byte check is enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned   B         = INSTR_W,
    parameter int unsigned   N_ADDR    = 10,
    parameter logic [B-1:0]  HALT_WORD = B'(HALT_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [N_ADDR-1:0] imem_addr,
    output logic [B-1:0]      imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_enable,
    output logic              overflow_err,
    output logic [N_ADDR:0]   word_count
);

    localparam logic [N_ADDR-1:0] PTR_MAX = '1;

    state_t            state_q, state_d;
    logic [N_ADDR-1:0] ptr_q, ptr_d;
    logic [N_ADDR-1:0] addr_q, addr_d;
    logic [B-1:0]      wdata_q, wdata_d;
    logic [N_ADDR:0]   wc_q, wc_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_en_q, cpu_en_d;
    logic              ovf_q, ovf_d;
    logic              pack_valid;
    logic              word_valid_c;
    logic [B-1:0]      word_c;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // start wins over a same-cycle byte, so the byte never reaches the packer.
    assign pack_valid = (state_q == ST_LOAD) && rx_valid && !start;

    byte_packer #(
        .B   (B),
        .BPW (B / 8)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (start),
        .byte_valid   (pack_valid),
        .byte_data    (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wc_q     <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wc_q     <= wc_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cpu_en_q <= cpu_en_d;
            ovf_q    <= ovf_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Next state and next values of the write port and status flags.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        if (start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            wc_d    = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (pack_valid) begin
                        csum_d = csum_q ^ rx_data;
                    end
`endif
                    if (word_valid_c) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word_c;
                        wc_d    = wc_q + (N_ADDR + 1)'(1);
                        // Pointer saturates at the top address instead of wrapping.
                        if (ptr_q != PTR_MAX) begin
                            ptr_d = ptr_q + N_ADDR'(1);
                        end
                        if (word_c == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        end else if (ptr_q == PTR_MAX) begin
                            state_d = ST_ERROR;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                default: begin
                end
            endcase
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        busy_d = (state_d == ST_LOAD) || (state_d == ST_CHK);
`else
        busy_d = (state_d == ST_LOAD);
`endif
        done_d   = (state_d == ST_DONE);
        cpu_en_d = (state_d == ST_DONE);
        ovf_d    = (state_d == ST_ERROR);
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cpu_enable   = cpu_en_q;
    assign overflow_err = ovf_q;
    assign word_count   = wc_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Streams a program image from a byte source, typically the UART receiver, into instruction memory.
- Packs every 4 bytes big-endian into a 32-bit instruction word. These are the opcode/func words the instruction-decode stage later consumes.
- Writes each word at an incrementing word address. It stops on a HALT word, then releases the CPU through cpu_enable.
- Sits between the serial front end and the IF-stage instruction memory write port.

Parameters:
B, 32, instruction word width; must be a multiple of 8
N_ADDR, 10, instruction memory word-address width
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is itself written to memory

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins or restarts a load
rx_data  in  8  incoming byte
rx_valid  in  1  byte strobe; at most one byte per cycle, no backpressure
imem_we  out  1  instruction memory write enable, one-cycle pulse per word
imem_addr  out  N_ADDR  word address for the write
imem_wdata  out  B  assembled instruction word
busy  out  1  high in LOAD (and CHK when enabled)
done  out  1  level, high in DONE
cpu_enable  out  1  level, high only in DONE; gates the pipeline clock-enable
overflow_err  out  1  level, high in ERROR
word_count  out  N_ADDR+1  words written in the current load, HALT included

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. Word pointer, byte counter, shift register and checksum cleared.
- FSM states: IDLE, LOAD, DONE, ERROR; CHK is added only with the optional feature.
- IDLE: rx_valid is ignored. start -> LOAD; pointer, byte counter, word_count and checksum are cleared.
- LOAD, byte accept: each rx_valid shifts rx_data into the low byte; the first byte of a word ends up in bits [31:24]. byte_cnt counts 0..B/8-1.
- LOAD, word complete: the cycle rx_valid arrives with byte_cnt==B/8-1 completes the word. On the next cycle:
  - imem_we=1, imem_addr=pointer, imem_wdata=word (registered outputs);
  - pointer increments and word_count increments.
  - Latency is 1 cycle from the last byte strobe to the write.
- Back-to-back bytes: rx_valid every cycle is legal. The next word's bytes keep shifting while the previous write is on the port. No byte is dropped.
- HALT: if the completed word == HALT_WORD, it is written as usual, then state -> DONE (or CHK) on the write cycle. Any further rx_valid is ignored.
- Capacity: a non-HALT word written at address 2^N_ADDR-1 means the pointer would wrap. The write still occurs, then state -> ERROR. The pointer never wraps to 0.
- DONE: done=1, cpu_enable=1, imem_we=0.
- ERROR: overflow_err=1, cpu_enable=0.
- start in LOAD: restarts the load. Counters are cleared and any partial word is discarded; memory contents are not erased.
- start in DONE or ERROR: same clearing, then -> LOAD. cpu_enable and done drop on the next cycle.
- start and rx_valid in the same cycle: start wins and the byte is discarded.
- Reset mid-load: returns to IDLE. Partial memory contents are left as-is; cpu_enable=0.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro: a running XOR is kept over every accepted byte, HALT bytes included. After the HALT write, state -> CHK (busy=1). The next rx_valid byte is compared with the running XOR:
  - equal -> DONE;
  - different -> ERROR (overflow_err=1, shared error flag).
  - start in CHK restarts the load.
- Without the macro: no CHK state and no XOR register. HALT goes directly to DONE.

Decomposition:
- Shared package (cpu_pkg): INSTR_W=32, BYTES_PER_WORD=4, default HALT_WORD, and a state enum localparam set (IDLE=0, LOAD=1, DONE=2, ERROR=3, CHK=4).
- Sub-module: byte_packer. It holds the shift register and byte counter, and emits word_valid plus word. The loader FSM owns the pointer, write port and status outputs.

Test Plan:
- Reset and idle: assert reset mid-cycle, then send rx_valid bytes without start -> all outputs 0, imem_we never asserted.
- Basic load: start, then bytes 20 08 00 05, FF FF FF FF, one per cycle -> writes 0x20080005@0 and 0xFFFFFFFF@1. imem_we pulses exactly 1 cycle after bytes 4 and 8. done=cpu_enable=1, word_count=2.
- Gapped stream plus restart: 3 bytes, idle 5 cycles, start, then a full word 0x00000020 and HALT -> partial word discarded; first write is 0x00000020@0.
- Overflow: N_ADDR=2, 4 non-HALT words -> 4 writes at 0..3, then overflow_err=1, cpu_enable=0. A 5th word produces no write.
- Same-cycle start and rx_valid, and start in DONE: the byte is dropped; done falls 1 cycle after start; the new load begins at address 0.
- With PROGRAM_LOADER_CHECKSUM_EN: word 0x01020304 then HALT, then checksum byte 0x04 -> DONE. Repeating with checksum 0x05 -> ERROR.
